// File: rtl/snoop_bus_pkg.sv
// rtl/snoop_bus_pkg.sv - shared encodings for the snooping bus arbiter
package snoop_bus_pkg;

  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    WRITE_MISS = 2'b00,
    READ_MISS  = 2'b01,
    INVALIDATE = 2'b10,
    WRITE_BACK = 2'b11
  } bus_msg_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BCAST   = 3'd1,
    COLLECT = 3'd2,
    MEM_RD  = 3'd3,
    MEM_WR  = 3'd4,
    DONE    = 3'd5
  } bus_state_e;

  typedef enum logic [1:0] {
    INVALID   = 2'b00,
    SHARED    = 2'b01,
    EXCLUSIVE = 2'b10,
    MODIFIED  = 2'b11
  } blk_state_e;

  function automatic logic more_than_one(input logic [31:0] v);
    return (v & (v - 32'd1)) != 32'd0;
  endfunction

endpackage

// File: rtl/snoop_bus_arbiter_rr_arbiter.sv
// rtl/snoop_bus_arbiter_rr_arbiter.sv - round-robin one-hot grant, pointer moves on accept
module rr_arbiter
  import snoop_bus_pkg::*;
#(
  parameter int N     = 3,
  parameter int PIDX_W = IDX_W
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic [N-1:0]      req_i,
  input  logic              accept_i,
  output logic [N-1:0]      grant_o,
  output logic [PIDX_W-1:0] idx_o
);

  logic [PIDX_W-1:0] ptr_q;
  logic [PIDX_W-1:0] cand;
  logic              found;

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 1; i <= N; i++) begin
      cand = PIDX_W'((int'(ptr_q) + i) % N);
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_q <= PIDX_W'(N - 1);
    end else if (accept_i && found) begin
      ptr_q <= idx_o;
    end
  end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// rtl/snoop_bus_arbiter.sv - serialises cache bus requests: broadcast, snoop collect, memory, done
module snoop_bus_arbiter
  import snoop_bus_pkg::*;
#(
  parameter int N_CACHES      = 3,
  parameter int ADDR_W        = 4,
  parameter int SNOOP_TIMEOUT = 8
) (
  input  logic                       clock_i,
  input  logic                       reset_n_i,
  input  logic [N_CACHES-1:0]        req_valid_i,
  input  logic [2*N_CACHES-1:0]      req_msg_i,
  input  logic [ADDR_W*N_CACHES-1:0] req_addr_i,
  output logic [N_CACHES-1:0]        req_accept_o,
  output logic                       bcast_valid_o,
  output logic [1:0]                 bcast_msg_o,
  output logic [ADDR_W-1:0]          bcast_addr_o,
  output logic [1:0]                 bcast_src_o,
  output logic [N_CACHES-1:0]        bcast_focus_o,
  input  logic [N_CACHES-1:0]        snoop_ack_i,
  input  logic [N_CACHES-1:0]        snoop_wb_i,
  output logic                       mem_valid_o,
  output logic                       mem_we_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  input  logic                       mem_ready_i,
  output logic                       done_valid_o,
  output logic [1:0]                 done_src_o,
  output logic                       done_wb_o,
  output logic                       done_err_o
);

  localparam int CNT_W = $clog2(SNOOP_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SNOOP_TIMEOUT - 1);

  bus_state_e          state_q;
  logic [1:0]          msg_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          src_q;
  logic [N_CACHES-1:0] focus_q, ack_q, wb_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                bcast_valid_q, mem_valid_q, mem_we_q;
  logic                done_valid_q, done_wb_q, done_err_q;

  logic [N_CACHES-1:0] grant;
  logic [1:0]          gnt_idx;
  logic [1:0]          sel_msg;
  logic [ADDR_W-1:0]   sel_addr;
  logic [N_CACHES-1:0] ack_d, wb_d;
  logic                all_acked;

  rr_arbiter #(.N(N_CACHES), .PIDX_W(2)) u_rr (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .req_i     (req_valid_i),
    .accept_i  (state_q == IDLE),
    .grant_o   (grant),
    .idx_o     (gnt_idx)
  );

  always_comb begin
    sel_msg  = '0;
    sel_addr = '0;
    for (int i = 0; i < N_CACHES; i++) begin
      if (grant[i]) begin
        sel_msg  = req_msg_i[2*i +: 2];
        sel_addr = req_addr_i[ADDR_W*i +: ADDR_W];
      end
    end
  end

  // Include this cycle's responses so the last ack completes without an extra cycle.
  assign ack_d     = ack_q | (snoop_ack_i & focus_q);
  assign wb_d      = wb_q | (snoop_wb_i & focus_q);
  assign all_acked = (ack_d == focus_q);

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= IDLE;
      msg_q         <= '0;
      addr_q        <= '0;
      src_q         <= '0;
      focus_q       <= '0;
      ack_q         <= '0;
      wb_q          <= '0;
      cnt_q         <= '0;
      bcast_valid_q <= 1'b0;
      mem_valid_q   <= 1'b0;
      mem_we_q      <= 1'b0;
      done_valid_q  <= 1'b0;
      done_wb_q     <= 1'b0;
      done_err_q    <= 1'b0;
    end else begin
      bcast_valid_q <= 1'b0;
      done_valid_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req_valid_i) begin
            msg_q         <= sel_msg;
            addr_q        <= sel_addr;
            src_q         <= gnt_idx;
            focus_q       <= ~grant;
            bcast_valid_q <= 1'b1;
            state_q       <= BCAST;
          end
        end
        BCAST: begin
          ack_q      <= '0;
          wb_q       <= '0;
          cnt_q      <= '0;
          done_wb_q  <= 1'b0;
          done_err_q <= 1'b0;
          if (msg_q == WRITE_BACK) begin
            mem_valid_q <= 1'b1;
            mem_we_q    <= 1'b1;
            state_q     <= MEM_WR;
          end else begin
            state_q <= COLLECT;
          end
        end
        COLLECT: begin
          ack_q <= ack_d;
          wb_q  <= wb_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (all_acked) begin
            if (more_than_one(32'(wb_d))) begin
              done_err_q   <= 1'b1;
              done_valid_q <= 1'b1;
              state_q      <= DONE;
            end else if (|wb_d) begin
              done_wb_q   <= 1'b1;
              mem_valid_q <= 1'b1;
              mem_we_q    <= 1'b1;
              state_q     <= MEM_WR;
            end else if (msg_q == INVALIDATE) begin
              done_valid_q <= 1'b1;
              state_q      <= DONE;
            end else begin
              mem_valid_q <= 1'b1;
              mem_we_q    <= 1'b0;
              state_q     <= MEM_RD;
            end
          end else if (cnt_q == CNT_LAST) begin
            done_err_q   <= 1'b1;
            done_valid_q <= 1'b1;
            state_q      <= DONE;
          end
        end
        MEM_RD, MEM_WR: begin
          if (mem_ready_i) begin
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            done_valid_q <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_accept_o  = (state_q == IDLE) ? grant : '0;
  assign bcast_valid_o = bcast_valid_q;
  assign bcast_msg_o   = msg_q;
  assign bcast_addr_o  = addr_q;
  assign bcast_src_o   = src_q;
  assign bcast_focus_o = focus_q;
  assign mem_valid_o   = mem_valid_q;
  assign mem_we_o      = mem_we_q;
  assign mem_addr_o    = addr_q;
  assign done_valid_o  = done_valid_q;
  assign done_src_o    = src_q;
  assign done_wb_o     = done_wb_q;
  assign done_err_o    = done_err_q;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// tb/tb_snoop_bus_arbiter.sv - directed bench with a cycle-timeline model of the snoop bus
module tb_snoop_bus_arbiter;
  import snoop_bus_pkg::*;

  localparam int NC = 512;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req_valid = '0;
  logic [5:0] req_msg = '0;
  logic [11:0] req_addr = '0;
  logic [2:0] req_accept;
  logic       bcast_valid;
  logic [1:0] bcast_msg;
  logic [3:0] bcast_addr;
  logic [1:0] bcast_src;
  logic [2:0] bcast_focus;
  logic [2:0] snoop_ack = '0;
  logic [2:0] snoop_wb = '0;
  logic       mem_valid, mem_we;
  logic [3:0] mem_addr;
  logic       mem_ready = 1'b0;
  logic       done_valid, done_wb, done_err;
  logic [1:0] done_src;

  always #5 clk = ~clk;

  snoop_bus_arbiter #(.N_CACHES(3), .ADDR_W(4), .SNOOP_TIMEOUT(TO)) dut (
    .clock_i(clk), .reset_n_i(rst_n),
    .req_valid_i(req_valid), .req_msg_i(req_msg), .req_addr_i(req_addr),
    .req_accept_o(req_accept),
    .bcast_valid_o(bcast_valid), .bcast_msg_o(bcast_msg), .bcast_addr_o(bcast_addr),
    .bcast_src_o(bcast_src), .bcast_focus_o(bcast_focus),
    .snoop_ack_i(snoop_ack), .snoop_wb_i(snoop_wb),
    .mem_valid_o(mem_valid), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_ready_i(mem_ready),
    .done_valid_o(done_valid), .done_src_o(done_src), .done_wb_o(done_wb), .done_err_o(done_err)
  );

  // Per-cycle stimulus and expected outputs, filled in before the run.
  logic       st_rst [NC];
  logic       st_req [NC][3];
  logic [1:0] st_msg [NC][3];
  logic [3:0] st_addr[NC][3];
  logic       st_ack [NC][3];
  logic       st_wb  [NC][3];
  logic       st_rdy [NC];
  logic [2:0] ex_acc [NC];
  logic       ex_bc  [NC];
  logic [1:0] ex_bmsg[NC];
  logic [3:0] ex_baddr[NC];
  logic [1:0] ex_bsrc[NC];
  logic [2:0] ex_bfoc[NC];
  logic       ex_mem [NC];
  logic       ex_we  [NC];
  logic [3:0] ex_maddr[NC];
  logic       ex_done[NC];
  logic [1:0] ex_dsrc[NC];
  logic       ex_dwb [NC];
  logic       ex_derr[NC];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int m_ptr = 2;
  bit running = 1'b0;
  int acc_cyc[$];
  logic [2:0] acc_vec[$];
  int done_cyc[$];
  logic [2:0] foc_seen[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int pick(input logic [2:0] m);
    for (int i = 1; i <= 3; i++) begin
      if (m[2'((m_ptr + i) % 3)]) return (m_ptr + i) % 3;
    end
    return -1;
  endfunction

  task automatic clear_range(input int lo, input int hi);
    for (int c = lo; c <= hi; c++) begin
      st_rst[c] = 0; st_rdy[c] = 0;
      ex_acc[c] = '0; ex_bc[c] = 0; ex_mem[c] = 0; ex_done[c] = 0;
      ex_bmsg[c] = '0; ex_baddr[c] = '0; ex_bsrc[c] = '0; ex_bfoc[c] = '0;
      ex_we[c] = 0; ex_maddr[c] = '0; ex_dsrc[c] = '0; ex_dwb[c] = 0; ex_derr[c] = 0;
      for (int i = 0; i < 3; i++) begin
        st_req[c][i] = 0; st_msg[c][i] = '0; st_addr[c][i] = '0; st_ack[c][i] = 0; st_wb[c][i] = 0;
      end
    end
  endtask

  // Transaction from accept cycle t0: derives every output cycle from the bus rules.
  task automatic plan_txn(input int t0, input int src, input logic [1:0] msg, input logic [3:0] addr,
                          input int a0, input int a1, input int a2, input logic [2:0] wbm,
                          input int mw, input bit noise, output int td);
    int ad[3];
    logic [2:0] focus;
    int c0, last, nwb, m0;
    bit missing, err, owner, domem, we;
    ad[0] = a0; ad[1] = a1; ad[2] = a2;
    focus = 3'b111 & ~(3'b001 << src);
    st_req[t0][src] = 1'b1; st_msg[t0][src] = msg; st_addr[t0][src] = addr;
    ex_acc[t0] = 3'b001 << src;
    ex_bc[t0+1] = 1'b1; ex_bmsg[t0+1] = msg; ex_baddr[t0+1] = addr;
    ex_bsrc[t0+1] = 2'(src); ex_bfoc[t0+1] = focus;
    err = 0; owner = 0; domem = 0; we = 0; c0 = t0 + 2; m0 = t0 + 2;
    if (msg != WRITE_BACK) begin
      last = 0; missing = 0; nwb = 0;
      if (noise) begin st_ack[c0][src] = 1'b1; st_wb[c0][src] = 1'b1; end
      for (int k = 0; k < 3; k++) begin
        if (focus[2'(k)]) begin
          if (ad[k] < 0) missing = 1;
          else begin
            st_ack[c0+ad[k]][k] = 1'b1;
            st_wb[c0+ad[k]][k] = wbm[2'(k)];
            if (ad[k] > last) last = ad[k];
            if (wbm[2'(k)]) nwb++;
          end
        end
      end
      if (missing || last > TO - 1) begin
        err = 1; m0 = c0 + TO;
      end else begin
        m0 = c0 + last + 1;
        if (nwb > 1) err = 1;
        else if (nwb == 1) begin owner = 1; domem = 1; we = 1; end
        else if (msg != INVALIDATE) domem = 1;
      end
    end else begin
      domem = 1; we = 1;
    end
    td = m0;
    if (domem) begin
      for (int t = m0; t <= m0 + mw; t++) begin ex_mem[t] = 1'b1; ex_we[t] = we; ex_maddr[t] = addr; end
      st_rdy[m0+mw] = 1'b1;
      td = m0 + mw + 1;
    end
    ex_done[td] = 1'b1; ex_dsrc[td] = 2'(src); ex_dwb[td] = owner; ex_derr[td] = err;
    m_ptr = src;
  endtask

  always @(negedge clk) begin
    if (running) begin
      chk("req_accept", 32'(req_accept), 32'(ex_acc[cyc]));
      chk("bcast_valid", 32'(bcast_valid), 32'(ex_bc[cyc]));
      if (ex_bc[cyc]) begin
        chk("bcast_msg", 32'(bcast_msg), 32'(ex_bmsg[cyc]));
        chk("bcast_addr", 32'(bcast_addr), 32'(ex_baddr[cyc]));
        chk("bcast_src", 32'(bcast_src), 32'(ex_bsrc[cyc]));
        chk("bcast_focus", 32'(bcast_focus), 32'(ex_bfoc[cyc]));
      end
      chk("mem_valid", 32'(mem_valid), 32'(ex_mem[cyc]));
      if (ex_mem[cyc]) begin
        chk("mem_we", 32'(mem_we), 32'(ex_we[cyc]));
        chk("mem_addr", 32'(mem_addr), 32'(ex_maddr[cyc]));
      end
      chk("done_valid", 32'(done_valid), 32'(ex_done[cyc]));
      if (ex_done[cyc]) begin
        chk("done_src", 32'(done_src), 32'(ex_dsrc[cyc]));
        chk("done_wb", 32'(done_wb), 32'(ex_dwb[cyc]));
        chk("done_err", 32'(done_err), 32'(ex_derr[cyc]));
      end
      if (req_accept != 3'b000) begin acc_cyc.push_back(cyc); acc_vec.push_back(req_accept); end
      if (done_valid) done_cyc.push_back(cyc);
      if (bcast_valid) foc_seen.push_back(bcast_focus);
    end
  end

  initial begin
    int t, td, s, t4, last0, ta, r, tb0, ncyc;
    logic [2:0] ord[6];
    ord[0] = 3'b001; ord[1] = 3'b010; ord[2] = 3'b100;
    ord[3] = 3'b001; ord[4] = 3'b010; ord[5] = 3'b100;
    clear_range(0, NC - 1);
    st_rst[0] = 1; st_rst[1] = 1; st_rst[2] = 1;
    t = 5;
    // 1: cache 1 READ_MISS, requester's own ack/wb must be ignored
    plan_txn(t, 1, READ_MISS, 4'hA, 0, -1, 0, 3'b000, 2, 1'b1, td); t = td + 1;
    // 2: cache 0 WRITE_MISS, cache 2 owns the block
    plan_txn(t, 0, WRITE_MISS, 4'h3, -1, 0, 1, 3'b100, 1, 1'b0, td); t = td + 1;
    // 3: cache 2 INVALIDATE, stray mem_ready while collecting
    plan_txn(t, 2, INVALIDATE, 4'h5, 0, 0, -1, 3'b000, 0, 1'b0, td);
    st_rdy[t+2] = 1'b1; t = td + 1;
    // 4: all caches request continuously
    t4 = t; last0 = t;
    for (int k = 0; k < 6; k++) begin
      s = pick(3'b111); last0 = t;
      plan_txn(t, s, INVALIDATE, 4'(8 + s), 0, 0, 0, 3'b000, 0, 1'b0, td); t = td + 1;
    end
    for (int c = t4; c <= last0; c++) begin
      for (int i = 0; i < 3; i++) begin
        st_req[c][i] = 1'b1; st_msg[c][i] = INVALIDATE; st_addr[c][i] = 4'(8 + i);
      end
    end
    // 5: cache 2 never acks
    plan_txn(t, 0, READ_MISS, 4'h1, -1, 0, -1, 3'b000, 0, 1'b0, td); t = td + 1;
    // write-back skips snooping
    plan_txn(t, 1, WRITE_BACK, 4'h7, -1, -1, -1, 3'b000, 0, 1'b0, td); t = td + 1;
    // two owners claim the block
    plan_txn(t, 2, READ_MISS, 4'h9, 0, 0, -1, 3'b011, 0, 1'b0, td); t = td + 1;
    // final ack lands on the last allowed collect cycle
    plan_txn(t, 1, INVALIDATE, 4'hC, 0, -1, TO - 1, 3'b000, 0, 1'b0, td); t = td + 1;
    // 6: reset during MEM_RD
    ta = t;
    plan_txn(ta, 0, READ_MISS, 4'h6, -1, 0, 0, 3'b000, 10, 1'b0, td);
    r = ta + 5;
    clear_range(r, td);
    st_rst[r] = 1; st_rst[r+1] = 1;
    m_ptr = 2;
    t = r + 3; tb0 = t;
    s = pick(3'b011);
    plan_txn(t, s, INVALIDATE, 4'h2, 0, 0, 0, 3'b000, 0, 1'b0, td); t = td + 1;
    s = pick(3'b010);
    plan_txn(t, s, INVALIDATE, 4'hE, 0, 0, 0, 3'b000, 0, 1'b0, td);
    for (int c = tb0; c <= t; c++) begin
      st_req[c][1] = 1'b1; st_msg[c][1] = INVALIDATE; st_addr[c][1] = 4'hE;
    end
    ncyc = td + 6;

    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      cyc = c;
      rst_n     = !st_rst[c];
      req_valid = {st_req[c][2], st_req[c][1], st_req[c][0]};
      req_msg   = {st_msg[c][2], st_msg[c][1], st_msg[c][0]};
      req_addr  = {st_addr[c][2], st_addr[c][1], st_addr[c][0]};
      snoop_ack = {st_ack[c][2], st_ack[c][1], st_ack[c][0]};
      snoop_wb  = {st_wb[c][2], st_wb[c][1], st_wb[c][0]};
      mem_ready = st_rdy[c];
      running   = 1'b1;
    end
    @(negedge clk); #1;
    running = 1'b0;

    chk("accept_count", 32'(acc_cyc.size()), 32'd16);
    chk("done_count", 32'(done_cyc.size()), 32'd15);
    if (acc_cyc.size() >= 16 && done_cyc.size() >= 13 && foc_seen.size() >= 1) begin
      chk("t1_focus", 32'(foc_seen[0]), 32'h5);
      chk("t1_latency", 32'(done_cyc[0] - acc_cyc[0]), 32'd6);
      chk("t3_latency", 32'(done_cyc[2] - acc_cyc[2]), 32'd3);
      for (int k = 0; k < 6; k++) chk("rr_order", 32'(acc_vec[3+k]), 32'(ord[k]));
      chk("t5_timeout_latency", 32'(done_cyc[9] - acc_cyc[9]), 32'd10);
      chk("last_ack_latency", 32'(done_cyc[12] - acc_cyc[12]), 32'd10);
      chk("post_reset_first", 32'(acc_vec[14]), 32'h1);
      chk("post_reset_second", 32'(acc_vec[15]), 32'h2);
    end else begin
      errors++; checks++;
      $display("FAIL event_log: accepts %0d dones %0d, required 16 and 15", acc_cyc.size(), done_cyc.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
